// File: rtl/voxel_bram_responder.sv
// voxel_bram_responder: memory-side responder for the voxel cache BRAM port.
// Holds 2^ADDR_W voxel words in an inferred block RAM. Read data comes back
// through a READ_LAT-deep pipeline (legal 1..4). After reset, and on
// clear_req, a sweep zeroes the whole array while ready is held low.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   bram_read_en          read strobe (one request per high cycle)
//   bram_write_en         write strobe (one request per high cycle)
//   bram_addr             address shared by both strobes
//   bram_wdata            write data
//   clear_req             pulse: start a full-array clear sweep
//   rd_data / rd_valid    read result and its qualifier
//   rd_perr               parity error on rd_data (qualified by rd_valid)
//   ready                 requests are accepted
//   clear_busy            clear sweep in progress
//   drop_cnt              saturating count of strobe cycles ignored while not ready
//
// Optional feature: define VOXEL_BRAM_PARITY_EN to store one even-parity bit
// per word and check it on every read. Undefined: no parity logic, rd_perr = 0.
module voxel_bram_responder #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bram_read_en,
  input  logic              bram_write_en,
  input  logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_wdata,
  input  logic              clear_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_perr,
  output logic              ready,
  output logic              clear_busy,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef VOXEL_BRAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        drop_q, drop_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [MEM_W-1:0]   mem [DEPTH];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [MEM_W-1:0]   mem_wdata;
  logic               rd_take;
  logic [MEM_W-1:0]   wr_word;
  logic [MEM_W-1:0]   rd_word;
  logic               rd_perr_c;

  logic [DATA_W-1:0]  pd_q [READ_LAT];
  logic               pv_q [READ_LAT];
  logic               pe_q [READ_LAT];

  // Stored word for a controller write, with its parity bit when enabled.
`ifdef VOXEL_BRAM_PARITY_EN
  assign wr_word = {^bram_wdata, bram_wdata};
`else
  assign wr_word = bram_wdata;
`endif

  // Write-first: a same-cycle write supplies the read data directly.
  always_comb begin
    rd_word = mem[bram_addr];
    if (bram_write_en) begin
      rd_word = wr_word;
    end
  end

  // Even parity over data plus stored bit must reduce to zero.
`ifdef VOXEL_BRAM_PARITY_EN
  assign rd_perr_c = ^rd_word;
`else
  assign rd_perr_c = 1'b0;
`endif

  // Next-state, memory port control and drop counting.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    drop_d    = drop_q;
    mem_we    = 1'b0;
    mem_waddr = bram_addr;
    mem_wdata = wr_word;
    rd_take   = 1'b0;
    case (state_q)
      CLEAR: begin
        // All-zero word has even parity, so '0 is a valid stored word.
        mem_we    = 1'b1;
        mem_waddr = ptr_q[ADDR_W-1:0];
        mem_wdata = '0;
        ptr_d     = ptr_q + PTR_W'(1);
        if (ptr_d[ADDR_W]) begin
          state_d = SERVE;
        end
        if ((bram_read_en || bram_write_en) && (drop_q != 16'hFFFF)) begin
          drop_d = drop_q + 16'd1;
        end
      end
      SERVE: begin
        mem_we  = bram_write_en;
        rd_take = bram_read_en;
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
    ready_d = (state_d == SERVE);
    busy_d  = (state_d == CLEAR);
  end

  // FSM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      drop_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Block RAM array; no reset, contents are established by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read pipeline; data stages load only behind a valid so rd_data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pd_q[i] <= '0;
        pv_q[i] <= 1'b0;
        pe_q[i] <= 1'b0;
      end
    end else begin
      pv_q[0] <= rd_take;
      if (rd_take) begin
        pd_q[0] <= rd_word[DATA_W-1:0];
        pe_q[0] <= rd_perr_c;
      end
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
          pe_q[i] <= pe_q[i-1];
        end
      end
    end
  end

  assign rd_data    = pd_q[READ_LAT-1];
  assign rd_valid   = pv_q[READ_LAT-1];
  assign rd_perr    = pe_q[READ_LAT-1];
  assign ready      = ready_q;
  assign clear_busy = busy_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_voxel_bram_responder.sv
// Testbench for voxel_bram_responder (ADDR_W=6, READ_LAT=2). A driver issues
// strobes and pushes expected read results from an array model; a monitor
// pops and checks whenever rd_valid is high, including arrival cycle.
module tb_voxel_bram_responder;

  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned READ_LAT = 2;
  localparam int unsigned DEPTH    = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              bram_read_en;
  logic              bram_write_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              clear_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_perr;
  logic              ready;
  logic              clear_busy;
  logic [15:0]       drop_cnt;

  voxel_bram_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bram_read_en (bram_read_en),
    .bram_write_en(bram_write_en),
    .bram_addr    (bram_addr),
    .bram_wdata   (bram_wdata),
    .clear_req    (clear_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_perr      (rd_perr),
    .ready        (ready),
    .clear_busy   (clear_busy),
    .drop_cnt     (drop_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              pe;
    int unsigned       due;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] mem_m [DEPTH];
  int unsigned       drop_m = 0;
  int unsigned       cyc = 0;
  int unsigned       checks = 0;
  int unsigned       errors = 0;
  logic [DATA_W-1:0] last_data = '0;
  logic              flip_next = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
  endtask

  // One cycle of stimulus, presented at a negedge and sampled at the next posedge.
  task automatic step(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic clr);
    exp_t e;
    bram_read_en  = rd;
    bram_write_en = wr;
    bram_addr     = a;
    bram_wdata    = d;
    clear_req     = clr;
    if (ready) begin
      if (wr) mem_m[a] = d;
      if (rd) begin
        e.d   = mem_m[a];
        e.pe  = flip_next;
        e.due = cyc + READ_LAT;
        sb_q.push_back(e);
      end
      if (clr) model_zero();
    end else if (rd || wr) begin
      if (drop_m < 32'hFFFF) drop_m++;
    end
    @(negedge clk);
    bram_read_en  = 1'b0;
    bram_write_en = 1'b0;
    clear_req     = 1'b0;
  endtask

  // Count not-ready cycles until ready returns; strobes in the first 10, clr at clr_at.
  task automatic sweep_count(input string name, input int clr_at);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      step(n < 10, 1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)), '0, n == clr_at);
      n++;
    end
    chk(name, 32'(n), 32'd64);
    chk({name, "_busy"}, 32'(clear_busy), 32'd0);
  endtask

  // Monitor: every rd_valid must match the oldest expectation; otherwise rd_data holds.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_data = '0;
      end else if (rd_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid actual=1 required=0");
        end else begin
          e = sb_q.pop_front();
          chk("rd_data", rd_data, e.d);
          chk("rd_perr", 32'(rd_perr), 32'(e.pe));
          chk("rd_latency_cycle", cyc, e.due);
          last_data = e.d;
        end
      end else begin
        chk("rd_data_hold", rd_data, last_data);
      end
    end
  end

  initial begin
    logic [31:0] r;
    int w;
    rst_n         = 1'b0;
    bram_read_en  = 1'b0;
    bram_write_en = 1'b0;
    bram_addr     = '0;
    bram_wdata    = '0;
    clear_req     = 1'b0;
    model_zero();
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_perr", 32'(rd_perr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd1);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Reset sweep with 10 dropped reads.
    rst_n = 1'b1;
    sweep_count("sweep_after_reset", -1);
    chk("drop_after_sweep", 32'(drop_cnt), 32'd10);

    // Whole array reads zero, back to back.
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 1'b0, ADDR_W'(DEPTH - 1 - i), '0, 1'b0);

    // Read-after-write and same-cycle write-first.
    step(1'b0, 1'b1, 6'h12, 32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b0, 6'h12, '0, 1'b0);
    step(1'b1, 1'b1, 6'h05, 32'h0000A5A5, 1'b0);
    step(1'b1, 1'b0, 6'h05, '0, 1'b0);

    // Randomized mix over a small address window to force hits.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      step(r[0], r[1], ADDR_W'($urandom_range(0, 15)), $urandom, 1'b0);
    end

    // Clear with a same-cycle read; a second clear_req mid-sweep is ignored.
    step(1'b0, 1'b1, 6'h20, 32'h1, 1'b0);
    step(1'b1, 1'b0, 6'h20, '0, 1'b1);
    chk("ready_low_after_clear", 32'(ready), 32'd0);
    sweep_count("sweep_after_clear", 5);
    step(1'b1, 1'b0, 6'h20, '0, 1'b0);
    step(1'b1, 1'b0, 6'h12, '0, 1'b0);
    chk("drop_after_clear", 32'(drop_cnt), 32'(drop_m));

`ifdef VOXEL_BRAM_PARITY_EN
    // Corrupt one stored bit; the read must flag a parity error.
    step(1'b0, 1'b1, 6'h07, 32'h12345678, 1'b0);
    dut.mem[7][0] = ~dut.mem[7][0];
    mem_m[7] = mem_m[7] ^ 32'h1;
    flip_next = 1'b1;
    step(1'b1, 1'b0, 6'h07, '0, 1'b0);
    flip_next = 1'b0;
`endif

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b0);

    // Asynchronous reset with reads in flight.
    step(1'b0, 1'b1, 6'h03, 32'hCAFE0003, 1'b0);
    step(1'b1, 1'b0, 6'h03, '0, 1'b0);
    step(1'b1, 1'b0, 6'h03, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    model_zero();
    drop_m = 0;
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_busy", 32'(clear_busy), 32'd1);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_count("sweep_after_midrst", -1);
    step(1'b1, 1'b0, 6'h03, '0, 1'b0);
    step(1'b1, 1'b0, 6'h3F, '0, 1'b0);
    chk("drop_final", 32'(drop_cnt), 32'(drop_m));

    w = 0;
    while (sb_q.size() > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
